// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: edge-detects the receiver's done level, buffers bytes.
// Define UART_RX_FIFO_PERR_EN to store a parity-error tag with every entry.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            rddone,
    input  logic            perr,
    input  logic [7:0]      data_in,
    input  logic            rd_en,
    input  logic            clr_ovr,
    output logic [7:0]      rd_data,
    output logic            rd_perr,
    output logic            empty,
    output logic            full,
    output logic [ADDR_W:0] count,
    output logic            overrun
);

`ifdef UART_RX_FIFO_PERR_EN
    localparam int ENTRY_W = 9;
`else
    localparam int ENTRY_W = 8;
`endif

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic               rddone_q;
    logic               push_ev;
    logic               pop_ev;
    logic               do_push;
    logic               drop;

    // rddone stays high through the stop bit(s), so only its rising edge counts as a frame.
    assign push_ev = rddone & ~rddone_q;
    assign pop_ev  = rd_en & ~empty;
    // When full, a coincident pop frees the slot the push lands in.
    assign do_push = push_ev & (~full | pop_ev);
    assign drop    = push_ev & full & ~pop_ev;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

`ifdef UART_RX_FIFO_PERR_EN
    assign wr_entry = {perr, data_in};
    assign rd_perr  = head[8];
`else
    logic unused_perr;
    assign unused_perr = perr;
    assign wr_entry    = data_in;
    assign rd_perr     = 1'b0;
`endif

    assign head    = mem[rd_ptr];
    assign rd_data = head[7:0];

    always_ff @(posedge clk) begin
        if (!nrst) begin
            rddone_q <= 1'b0;
        end else begin
            rddone_q <= rddone;
        end
    end

    // Storage is not reset; stale contents are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (nrst && do_push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ev) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, pop_ev})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A new drop wins over a clear arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo; inputs change and outputs are sampled on negedge clk.
module tb_uart_rx_fifo;

`ifdef UART_RX_FIFO_PERR_EN
    localparam logic PERR_EN = 1'b1;
`else
    localparam logic PERR_EN = 1'b0;
`endif

    logic       clk;
    logic       nrst;
    logic       rddone;
    logic       perr;
    logic [7:0] data_in;
    logic       rd_en;
    logic       clr_ovr;
    logic [7:0] rd_data;
    logic       rd_perr;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk     (clk),
        .nrst    (nrst),
        .rddone  (rddone),
        .perr    (perr),
        .data_in (data_in),
        .rd_en   (rd_en),
        .clr_ovr (clr_ovr),
        .rd_data (rd_data),
        .rd_perr (rd_perr),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One received frame: rddone held for two edges, then low for one so the next frame is a new edge.
    task automatic applyStimulus(input logic [7:0] d, input logic p);
        rddone  = 1'b1;
        data_in = d;
        perr    = p;
        repeat (2) @(negedge clk);
        rddone = 1'b0;
        @(negedge clk);
    endtask

    task automatic popEntry(input string tag, input logic [7:0] expected);
        checkOutput(tag, {24'd0, rd_data}, {24'd0, expected});
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic checkFlags(input string tag, input int exp_count, input logic exp_empty,
                              input logic exp_full, input logic exp_ovr);
        checkOutput({tag, "_count"}, {27'd0, count}, 32'(exp_count));
        checkOutput({tag, "_empty"}, {31'd0, empty}, {31'd0, exp_empty});
        checkOutput({tag, "_full"}, {31'd0, full}, {31'd0, exp_full});
        checkOutput({tag, "_overrun"}, {31'd0, overrun}, {31'd0, exp_ovr});
    endtask

    initial begin
        nrst    = 1'b0;
        rddone  = 1'b0;
        perr    = 1'b0;
        data_in = 8'h00;
        rd_en   = 1'b0;
        clr_ovr = 1'b0;
        repeat (2) @(negedge clk);
        checkFlags("reset", 0, 1'b1, 1'b0, 1'b0);
        nrst = 1'b1;
        @(negedge clk);

        $display("[TB] long rddone level gives a single push");
        rddone  = 1'b1;
        data_in = 8'h5A;
        @(negedge clk);
        checkFlags("rise", 1, 1'b0, 1'b0, 1'b0);
        checkOutput("rise_data", {24'd0, rd_data}, 32'h5A);
        repeat (49) @(negedge clk);
        checkOutput("long_count", {27'd0, count}, 32'd1);
        rddone = 1'b0;
        @(negedge clk);
        popEntry("long_pop", 8'h5A);
        checkFlags("long_drained", 0, 1'b1, 1'b0, 1'b0);

        $display("[TB] fill, overflow, drain");
        for (int i = 1; i <= 16; i++) applyStimulus(8'(i), 1'b0);
        checkFlags("filled", 16, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h11, 1'b0);
        checkFlags("overflow", 16, 1'b0, 1'b1, 1'b1);
        rddone   = 1'b1;
        data_in  = 8'h12;
        clr_ovr  = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        checkOutput("clr_vs_drop", {31'd0, overrun}, 32'd1);
        rddone = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= 16; i++) popEntry($sformatf("drain_%0d", i), 8'(i));
        checkFlags("drained", 0, 1'b1, 1'b0, 1'b1);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        checkOutput("clr_ovr", {31'd0, overrun}, 32'd0);

        $display("[TB] push and pop together while full");
        for (int i = 0; i < 16; i++) applyStimulus(8'hB0 + 8'(i), 1'b0);
        rddone  = 1'b1;
        data_in = 8'hAA;
        rd_en   = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        checkFlags("full_pushpop", 16, 1'b0, 1'b1, 1'b0);
        rddone = 1'b0;
        @(negedge clk);
        for (int i = 1; i < 16; i++) popEntry($sformatf("fp_%0d", i), 8'hB0 + 8'(i));
        popEntry("fp_last", 8'hAA);
        checkFlags("fp_drained", 0, 1'b1, 1'b0, 1'b0);

        $display("[TB] pop while empty is ignored");
        rd_en = 1'b1;
        repeat (10) @(negedge clk);
        checkFlags("empty_pop", 0, 1'b1, 1'b0, 1'b0);
        rddone  = 1'b1;
        data_in = 8'h33;
        @(negedge clk);
        rd_en = 1'b0;
        checkOutput("empty_pushpop_count", {27'd0, count}, 32'd1);
        checkOutput("empty_pushpop_data", {24'd0, rd_data}, 32'h33);
        rddone = 1'b0;
        @(negedge clk);
        popEntry("empty_pushpop_pop", 8'h33);

        $display("[TB] parity tag");
        applyStimulus(8'h7E, 1'b1);
        applyStimulus(8'h7F, 1'b0);
        checkOutput("perr_head", {31'd0, rd_perr}, {31'd0, PERR_EN});
        popEntry("perr_pop0", 8'h7E);
        checkOutput("perr_next", {31'd0, rd_perr}, 32'd0);
        popEntry("perr_pop1", 8'h7F);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 5; i++) applyStimulus(8'h40 + 8'(i), 1'b0);
        checkOutput("pre_reset_count", {27'd0, count}, 32'd5);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        checkFlags("mid_reset", 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'hC3, 1'b0);
        checkOutput("post_reset_count", {27'd0, count}, 32'd1);
        popEntry("post_reset_data", 8'hC3);

        $display("[TB] reset clears overrun, rddone high across reset pushes once");
        for (int i = 0; i < 17; i++) applyStimulus(8'h80 + 8'(i), 1'b0);
        checkOutput("pre_reset_ovr", {31'd0, overrun}, 32'd1);
        nrst    = 1'b0;
        rddone  = 1'b1;
        data_in = 8'hE5;
        @(negedge clk);
        checkFlags("ovr_reset", 0, 1'b1, 1'b0, 1'b0);
        nrst = 1'b1;
        @(negedge clk);
        checkOutput("held_rddone_count", {27'd0, count}, 32'd1);
        checkOutput("held_rddone_data", {24'd0, rd_data}, 32'hE5);
        repeat (3) @(negedge clk);
        checkOutput("held_rddone_single", {27'd0, count}, 32'd1);
        rddone = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter: DEPTH, 16, number of FIFO entries; power of two, 2..256.
REQ-002 Parameter: ADDR_W, 4, pointer width; SHALL equal log2(DEPTH).
REQ-003 Port: clk  input  1  core clock; all logic on rising edge.
REQ-004 Port: nrst  input  1  reset; synchronous, active-low.
REQ-005 Port: rddone  input  1  receiver done level from the UART receiver; may stay high for many cycles during stop bit(s).
REQ-006 Port: perr  input  1  receiver parity-error flag; valid while rddone high.
REQ-007 Port: data_in  input  8  received byte (receiver data_out[7:0]); valid while rddone high.
REQ-008 Port: rd_en  input  1  pop request from the bus side.
REQ-009 Port: clr_ovr  input  1  clear sticky overrun flag.
REQ-010 Port: rd_data  output  8  head entry byte (first-word fall-through).
REQ-011 Port: rd_perr  output  1  parity-error tag of the head entry.
REQ-012 Port: empty  output  1  FIFO holds zero entries.
REQ-013 Port: full  output  1  FIFO holds DEPTH entries.
REQ-014 Port: count  output  ADDR_W+1  number of stored entries, 0..DEPTH.
REQ-015 Port: overrun  output  1  sticky: a byte was dropped because FIFO was full.

Function
REQ-016 Block SHALL register rddone into rddone_q each cycle; push event = rddone & ~rddone_q (exactly one push per received frame, for 1 or 2 stop bits).
REQ-017 On push event with FIFO not full: write {perr, data_in} at wr_ptr, wr_ptr+1 mod DEPTH, count+1.
REQ-018 Pop event = rd_en & ~empty; rd_en while empty SHALL be ignored (no pointer/count change, no error flag).
REQ-019 On pop event: rd_ptr+1 mod DEPTH, count-1; rd_data/rd_perr SHALL show the new head the following cycle.
REQ-020 rd_data/rd_perr SHALL always reflect entry at rd_ptr; value is don't-care when empty.
REQ-021 Push and pop in same cycle, FIFO neither empty nor full: both performed, count unchanged.
REQ-022 Push and pop in same cycle, FIFO empty: push performed, pop ignored, count becomes 1.
REQ-023 Push and pop in same cycle, FIFO full: pop performed first, push accepted, count stays DEPTH, overrun not set.
REQ-024 Push event with FIFO full and no pop: byte SHALL be dropped, pointers/count unchanged, overrun set to 1.
REQ-025 overrun SHALL hold until clr_ovr=1; clr_ovr and new overrun in same cycle -> overrun stays 1.
REQ-026 empty=(count==0), full=(count==DEPTH), both registered-consistent with count; latency from rddone rising (sampled) to empty=0 is 1 cycle.
REQ-027 Pointers SHALL wrap from DEPTH-1 to 0 with no lost or duplicated entry.

Reset
REQ-028 With nrst=0 at a clk edge: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overrun=0, rddone_q=0.
REQ-029 Reset mid-operation SHALL discard all stored entries; storage array contents are not reset.
REQ-030 rddone already high on the first cycle after reset SHALL produce one push event.

Configuration
REQ-031 Macro UART_RX_FIFO_PERR_EN defined: entries are 9 bits, perr stored per entry, rd_perr = head entry tag.
REQ-032 Macro UART_RX_FIFO_PERR_EN undefined: entries are 8 bits, perr input ignored, rd_perr tied to 0.

Verification
REQ-033 rddone high for 50 cycles with data_in=0x5A, perr=0 -> count=1 (single push), rd_data=0x5A, empty=0 one cycle after rddone rise.
REQ-034 Push 0x01..0x10 (16 frames), then push 0x11 -> full=1, count=16, overrun=1, 0x11 dropped; 16 pops return 0x01..0x10 in order, empty=1.
REQ-035 With FIFO full, push 0xAA coincident with rd_en -> count stays 16, overrun=0, last entry read out is 0xAA.
REQ-036 rd_en held high while empty for 10 cycles -> count=0, pointers unchanged; then push 0x33 coincident with rd_en -> count=1, rd_data=0x33.
REQ-037 Macro defined: push 0x7E with perr=1 then 0x7F with perr=0 -> rd_perr=1 for head 0x7E, rd_perr=0 after pop; macro undefined -> rd_perr=0 throughout.
REQ-038 Push 5 bytes, assert nrst=0 one cycle -> count=0, empty=1, overrun=0; next push 0xC3 read back as 0xC3.
